// File: rtl/usr_pkg.sv
// usr_pkg
//   Shared constants for the universal shift register: the 2-bit mode
//   encoding used by the top level and by every bit cell.
package usr_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_HOLD = 2'b00;
    localparam mode_t MODE_SHR  = 2'b01;
    localparam mode_t MODE_SHL  = 2'b10;
    localparam mode_t MODE_LOAD = 2'b11;

endpackage

// File: rtl/usr_bit_cell.sv
// usr_bit_cell
//   One storage bit of the universal shift register: a 4:1 next-state mux
//   feeding a D flip-flop with asynchronous active-low reset and
//   asynchronous active-high set (reset dominant).
//
// Ports
//   clk_i    rising-edge clock
//   rst_b_i  asynchronous reset, active-low, forces RST_VAL
//   set_i    asynchronous preset, active-high, forces SET_VAL
//   en_i     clock enable, 0 holds regardless of mode
//   mode_i   00 hold, 01 take shr_i, 10 take shl_i, 11 take d_i
//   shr_i    bit arriving from the left neighbour on a right shift
//   shl_i    bit arriving from the right neighbour on a left shift
//   d_i      parallel load bit
//   q_o      stored bit
module usr_bit_cell
    import usr_pkg::*;
#(
    parameter logic RST_VAL = 1'b0,
    parameter logic SET_VAL = 1'b1
) (
    input  logic  clk_i,
    input  logic  rst_b_i,
    input  logic  set_i,
    input  logic  en_i,
    input  mode_t mode_i,
    input  logic  shr_i,
    input  logic  shl_i,
    input  logic  d_i,
    output logic  q_o
);

    logic q_q;
    logic q_d;
    logic set_act;

    // Gating set with reset makes the set edge reappear when reset is
    // released while set is still held, so q jumps to SET_VAL at once.
    assign set_act = set_i & rst_b_i;

    always_comb begin
        q_d = q_q;
        if (en_i) begin
            case (mode_i)
                MODE_HOLD: q_d = q_q;
                MODE_SHR:  q_d = shr_i;
                MODE_SHL:  q_d = shl_i;
                MODE_LOAD: q_d = d_i;
                default:   q_d = q_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_b_i or posedge set_act) begin
        if (!rst_b_i) begin
            q_q <= RST_VAL;
        end else if (set_act) begin
            q_q <= SET_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/universal_shift_reg.sv
// universal_shift_reg
//   Parametrised universal shift register: hold, shift right, shift left
//   (serial fill or rotate) and parallel load, built from WIDTH bit cells.
//
// Ports
//   clk     rising-edge clock
//   reset   asynchronous reset, active-low, forces RESET_VAL
//   set     asynchronous preset, active-high, forces SET_VAL
//   en      clock enable, 0 holds
//   mode    00 hold, 01 shift right, 10 shift left, 11 parallel load
//   rotate  1 recirculates the outgoing bit instead of the serial input
//   sin_r   serial input into q[WIDTH-1] on shift right
//   sin_l   serial input into q[0] on shift left
//   d       parallel load data
//   q       register contents
//   qbar    ~q
//   sout_r  q[0]
//   sout_l  q[WIDTH-1]
//   zero    1 when q is all zeros
module universal_shift_reg
    import usr_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
    parameter logic [WIDTH-1:0] SET_VAL   = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             set,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             rotate,
    input  logic             sin_r,
    input  logic             sin_l,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             sout_r,
    output logic             sout_l,
    output logic             zero
);

    logic [WIDTH-1:0] shr_in;
    logic [WIDTH-1:0] shl_in;
    logic             end_in_r;
    logic             end_in_l;

    // For WIDTH = 1 both wrap-around bits are q[0] itself, so a rotate holds.
    assign end_in_r = rotate ? q[0]       : sin_r;
    assign end_in_l = rotate ? q[WIDTH-1] : sin_l;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (i == WIDTH - 1) begin : g_shr_end
            assign shr_in[i] = end_in_r;
        end else begin : g_shr_mid
            assign shr_in[i] = q[i+1];
        end

        if (i == 0) begin : g_shl_end
            assign shl_in[i] = end_in_l;
        end else begin : g_shl_mid
            assign shl_in[i] = q[i-1];
        end

        usr_bit_cell #(
            .RST_VAL (RESET_VAL[i]),
            .SET_VAL (SET_VAL[i])
        ) u_cell (
            .clk_i   (clk),
            .rst_b_i (reset),
            .set_i   (set),
            .en_i    (en),
            .mode_i  (mode),
            .shr_i   (shr_in[i]),
            .shl_i   (shl_in[i]),
            .d_i     (d[i]),
            .q_o     (q[i])
        );
    end

    assign qbar   = ~q;
    assign sout_r = q[0];
    assign sout_l = q[WIDTH-1];
    assign zero   = ~|q;

endmodule

// File: tb/tb_universal_shift_reg.sv
// tb_universal_shift_reg
//   Directed bench for universal_shift_reg: an 8-bit default instance and a
//   1-bit instance with RESET_VAL = 1 for the single-bit boundary cases.
module tb_universal_shift_reg;
    import usr_pkg::*;

    logic       clk;
    logic       reset;
    logic       set;
    logic       en;
    logic [1:0] mode;
    logic       rotate;
    logic       sin_r;
    logic       sin_l;
    logic [7:0] d;
    logic [7:0] q;
    logic [7:0] qbar;
    logic       sout_r;
    logic       sout_l;
    logic       zero;

    logic       w1_reset;
    logic       w1_set;
    logic       w1_en;
    logic [1:0] w1_mode;
    logic       w1_rotate;
    logic       w1_sin_r;
    logic       w1_sin_l;
    logic [0:0] w1_d;
    logic [0:0] w1_q;
    logic [0:0] w1_qbar;
    logic       w1_sout_r;
    logic       w1_sout_l;
    logic       w1_zero;

    int n_checks = 0;
    int n_fail   = 0;

    universal_shift_reg #(.WIDTH(8)) dut (
        .clk    (clk),
        .reset  (reset),
        .set    (set),
        .en     (en),
        .mode   (mode),
        .rotate (rotate),
        .sin_r  (sin_r),
        .sin_l  (sin_l),
        .d      (d),
        .q      (q),
        .qbar   (qbar),
        .sout_r (sout_r),
        .sout_l (sout_l),
        .zero   (zero)
    );

    universal_shift_reg #(.WIDTH(1), .RESET_VAL(1'b1), .SET_VAL(1'b1)) dut_w1 (
        .clk    (clk),
        .reset  (w1_reset),
        .set    (w1_set),
        .en     (w1_en),
        .mode   (w1_mode),
        .rotate (w1_rotate),
        .sin_r  (w1_sin_r),
        .sin_l  (w1_sin_l),
        .d      (w1_d),
        .q      (w1_q),
        .qbar   (w1_qbar),
        .sout_r (w1_sout_r),
        .sout_l (w1_sout_l),
        .zero   (w1_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One rising edge, then return to the falling edge where outputs are sampled.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #1;
        n_checks++;
        if (q !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_initial: q=%h expected 00", q);
        end
        reset = 1'b1;
        en = 1'b1; mode = MODE_LOAD; d = 8'hA5;
        tick();
        n_checks++;
        if (q !== 8'hA5) begin
            n_fail++;
            $display("FAIL load_a5: q=%h expected a5", q);
        end
        // Start a shift, then abort it with reset before the edge.
        mode = MODE_SHR; sin_r = 1'b1; rotate = 1'b0;
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (q !== 8'h00 || zero !== 1'b1 || qbar !== 8'hFF) begin
            n_fail++;
            $display("FAIL reset_async: q=%h zero=%b qbar=%h expected 00 1 ff", q, zero, qbar);
        end
        @(negedge clk);
        reset = 1'b1;
        tick();
        n_checks++;
        if (q !== 8'h80 || sout_l !== 1'b1 || sout_r !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_after_reset: q=%h sout_l=%b sout_r=%b expected 80 1 0", q, sout_l, sout_r);
        end
    endtask

    task automatic test_set();
        mode = MODE_LOAD; d = 8'h00; en = 1'b1;
        #1 set = 1'b1;
        #1;
        n_checks++;
        if (q !== 8'hFF || zero !== 1'b0) begin
            n_fail++;
            $display("FAIL set_async: q=%h zero=%b expected ff 0", q, zero);
        end
        tick();
        tick();
        n_checks++;
        if (q !== 8'hFF) begin
            n_fail++;
            $display("FAIL set_holds_over_edges: q=%h expected ff", q);
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if (q !== 8'h00) begin
            n_fail++;
            $display("FAIL set_and_reset: q=%h expected 00", q);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if (q !== 8'hFF) begin
            n_fail++;
            $display("FAIL reset_release_under_set: q=%h expected ff", q);
        end
        @(negedge clk);
        set = 1'b0;
        d = 8'h5A;
        tick();
        n_checks++;
        if (q !== 8'h5A) begin
            n_fail++;
            $display("FAIL load_after_set: q=%h expected 5a", q);
        end
    endtask

    task automatic test_load_shift();
        en = 1'b1; mode = MODE_LOAD; d = 8'h96; rotate = 1'b0;
        tick();
        n_checks++;
        if (q !== 8'h96 || sout_r !== 1'b0 || sout_l !== 1'b1) begin
            n_fail++;
            $display("FAIL load_96: q=%h sout_r=%b sout_l=%b expected 96 0 1", q, sout_r, sout_l);
        end
        mode = MODE_SHR; sin_r = 1'b1; sin_l = 1'b0;
        tick();
        n_checks++;
        if (q !== 8'hCB || sout_r !== 1'b1 || sout_l !== 1'b1 || qbar !== 8'h34) begin
            n_fail++;
            $display("FAIL shr_sin1: q=%h sout_r=%b sout_l=%b qbar=%h expected cb 1 1 34", q, sout_r, sout_l, qbar);
        end
        mode = MODE_SHL; sin_l = 1'b0; sin_r = 1'b1;
        tick();
        n_checks++;
        if (q !== 8'h96 || sout_r !== 1'b0 || sout_l !== 1'b1) begin
            n_fail++;
            $display("FAIL shl_sin0: q=%h sout_r=%b sout_l=%b expected 96 0 1", q, sout_r, sout_l);
        end
        sin_l = 1'b1;
        tick();
        n_checks++;
        if (q !== 8'h2D || sout_l !== 1'b0) begin
            n_fail++;
            $display("FAIL shl_sin1: q=%h sout_l=%b expected 2d 0", q, sout_l);
        end
    endtask

    task automatic test_rotate();
        logic [7:0] exp_r [3];
        logic [7:0] exp_l [3];
        exp_r = '{8'hC0, 8'h60, 8'h30};
        exp_l = '{8'h60, 8'hC0, 8'h81};
        en = 1'b1; mode = MODE_LOAD; d = 8'h81;
        tick();
        mode = MODE_SHR; rotate = 1'b1; sin_r = 1'b0; sin_l = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (q !== exp_r[i]) begin
                n_fail++;
                $display("FAIL rotr_step%0d: q=%h expected %h", i, q, exp_r[i]);
            end
        end
        mode = MODE_SHL;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (q !== exp_l[i]) begin
                n_fail++;
                $display("FAIL rotl_step%0d: q=%h expected %h", i, q, exp_l[i]);
            end
        end
        rotate = 1'b0;
    endtask

    task automatic test_enable_hold();
        en = 1'b0; mode = MODE_LOAD; d = 8'h3C;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (q !== 8'h81) begin
                n_fail++;
                $display("FAIL en0_hold_edge%0d: q=%h expected 81", i, q);
            end
        end
        en = 1'b1;
        tick();
        n_checks++;
        if (q !== 8'h3C) begin
            n_fail++;
            $display("FAIL en1_load: q=%h expected 3c", q);
        end
        mode = MODE_HOLD; d = 8'hFF;
        tick();
        n_checks++;
        if (q !== 8'h3C) begin
            n_fail++;
            $display("FAIL mode_hold: q=%h expected 3c", q);
        end
    endtask

    task automatic test_release_timing();
        en = 1'b1; mode = MODE_LOAD; d = 8'h55;
        reset = 1'b0;
        @(posedge clk);
        // Let the edge see reset still asserted, then release in the same cycle.
        #1 reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (q !== 8'h00) begin
            n_fail++;
            $display("FAIL release_edge: q=%h expected 00", q);
        end
        tick();
        n_checks++;
        if (q !== 8'h55) begin
            n_fail++;
            $display("FAIL release_next_edge: q=%h expected 55", q);
        end
    endtask

    task automatic test_width1();
        w1_reset = 1'b0;
        #1;
        n_checks++;
        if (w1_q !== 1'b1 || w1_zero !== 1'b0) begin
            n_fail++;
            $display("FAIL w1_reset_val: q=%b zero=%b expected 1 0", w1_q, w1_zero);
        end
        @(negedge clk);
        w1_reset = 1'b1;
        w1_en = 1'b1; w1_mode = MODE_LOAD; w1_d = 1'b0;
        tick();
        n_checks++;
        if (w1_q !== 1'b0 || w1_zero !== 1'b1) begin
            n_fail++;
            $display("FAIL w1_load0: q=%b zero=%b expected 0 1", w1_q, w1_zero);
        end
        w1_mode = MODE_SHR; w1_rotate = 1'b1; w1_sin_r = 1'b1; w1_sin_l = 1'b1;
        tick();
        n_checks++;
        if (w1_q !== 1'b0) begin
            n_fail++;
            $display("FAIL w1_rotr_hold: q=%b expected 0", w1_q);
        end
        w1_rotate = 1'b0; w1_sin_r = 1'b1; w1_sin_l = 1'b0;
        tick();
        n_checks++;
        if (w1_q !== 1'b1 || w1_sout_r !== 1'b1 || w1_sout_l !== 1'b1) begin
            n_fail++;
            $display("FAIL w1_shr_sin1: q=%b sout_r=%b sout_l=%b expected 1 1 1", w1_q, w1_sout_r, w1_sout_l);
        end
        w1_mode = MODE_SHL; w1_sin_l = 1'b0; w1_sin_r = 1'b1;
        tick();
        n_checks++;
        if (w1_q !== 1'b0) begin
            n_fail++;
            $display("FAIL w1_shl_sin0: q=%b expected 0", w1_q);
        end
    endtask

    initial begin
        reset = 1'b1; set = 1'b0; en = 1'b0; mode = MODE_HOLD;
        rotate = 1'b0; sin_r = 1'b0; sin_l = 1'b0; d = 8'h00;
        w1_reset = 1'b1; w1_set = 1'b0; w1_en = 1'b0; w1_mode = MODE_HOLD;
        w1_rotate = 1'b0; w1_sin_r = 1'b0; w1_sin_l = 1'b0; w1_d = 1'b0;
        @(negedge clk);

        test_reset();
        test_set();
        test_load_shift();
        test_rotate();
        test_enable_hold();
        test_release_timing();
        test_width1();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
